noc_packetizer: RTL and testbench
=================================

// Module: noc_packetizer
// PURPOSE
//  Network-interface source side: turns a packet descriptor plus a body-word stream into flit_t-format flits
//  (HEAD/BODY/TAIL/HEADTAIL) for a router LOCAL input port. Allocates one VC per packet (round-robin,
//  held until the tail) and gates every flit on per-VC downstream credits. Parametrised successor of the
//  fixed noc_params flit format: mesh size, VC count, payload width and packet length are generics.
// PARAMETERS
//  MESH_SIZE_X        5   mesh columns; DX = $clog2(MESH_SIZE_X)
//  MESH_SIZE_Y        5   mesh rows;    DY = $clog2(MESH_SIZE_Y)
//  VC_NUM             2   virtual channels (>=2); VS = $clog2(VC_NUM)
//  HEAD_PAYLOAD_SIZE  16  head payload bits; FD = DX+DY+HEAD_PAYLOAD_SIZE
//  MAX_BODY_FLITS     7   max flits after head; BC = $clog2(MAX_BODY_FLITS+1)
//  CREDIT_DEPTH       4   downstream buffer slots per VC (credit reset value); CW = $clog2(CREDIT_DEPTH+1)
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous active-high reset
//  pkt_valid_i      in   1        descriptor valid
//  pkt_ready_o      out  1        descriptor accepted when valid&ready
//  pkt_x_dest_i     in   DX       destination column
//  pkt_y_dest_i     in   DY       destination row
//  pkt_head_pl_i    in   HEAD_PAYLOAD_SIZE  head payload
//  pkt_body_cnt_i   in   BC       flits after head (0 = single HEADTAIL flit)
//  body_valid_i     in   1        body word valid
//  body_ready_o     out  1        body word accepted when valid&ready
//  body_data_i      in   FD       body/tail payload
//  flit_valid_o     out  1        registered flit strobe
//  flit_o           out  2+VS+FD  {label[1:0], vc_id, data}; label HEAD=0,BODY=1,TAIL=2,HEADTAIL=3
//  credit_valid_i   in   1        one credit returned
//  credit_vc_i      in   VS       VC of returned credit
//  busy_o           out  1        1 while state = BODY
//  err_o            out  1        sticky credit-overflow flag
// BEHAVIOUR
//  - Reset: state IDLE, every credit[v] = CREDIT_DEPTH, rr_ptr = 0, flit_valid_o = 0, flit_o = 0, err_o = 0.
//    pkt_ready_o and body_ready_o forced 0 while rst = 1.
//  - FSM IDLE -> BODY -> IDLE. Outputs flit_valid_o and flit_o are registered: 1-cycle latency from handshake.
//  - IDLE: sel_vc = first VC with credit > 0, searching from rr_ptr upward with wrap.
//    pkt_ready_o = any credit > 0 (comb). On accept: emit head {x,y,head_pl} on sel_vc; credit[sel_vc]--;
//    rr_ptr = sel_vc+1 (wraps to 0 past VC_NUM-1); label HEADTAIL if body_cnt = 0 (stay IDLE),
//    else HEAD, latch vc and remaining = body_cnt, go BODY.
//  - BODY: pkt_ready_o = 0; body_ready_o = credit[vc] > 0. On handshake emit body_data_i on held vc,
//    credit[vc]--, remaining--; label TAIL when remaining = 1 (-> IDLE), else BODY.
//    body_ready_o = 0 in IDLE; body stall inserts bubbles (flit_valid_o = 0), no timeout.
//  - pkt_body_cnt_i > MAX_BODY_FLITS is illegal; value is clamped to MAX_BODY_FLITS.
//  - Credits: credit_valid_i increments credit[credit_vc_i]. Same-cycle consume and return on one VC ->
//    value unchanged. Return that would exceed CREDIT_DEPTH: counter saturates, err_o set until rst.
//    credit_vc_i >= VC_NUM: ignored, err_o set.
//  - Credit return in the same cycle as a zero-credit check does not bypass: ready uses registered counts.
//  - Reset mid-packet: state, credits, rr_ptr restored; partial packet abandoned, no TAIL emitted.
// CONFIGURATION
//  NOC_PKT_STATS_EN defined: adds outputs pkt_cnt_o [15:0] (+1 per accepted descriptor) and
//    flit_cnt_o [15:0] (+1 per flit emitted); both wrap 0xFFFF->0, reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 rst, pkt x=3 y=2 pl=0xBEEF cnt=0 -> next cycle flit_valid_o=1, label HEADTAIL, vc 0, credit[0]=3.
//  2 pkt cnt=2 with body words 0xA,0xB -> HEAD, BODY(0xA), TAIL(0xB) on vc 1; next pkt gets vc 0.
//  3 defaults, 8 HEADTAIL pkts, no credits -> vcs alternate 0,1; pkt_ready_o=0 after 8th;
//    credit on vc1 -> next pkt emitted on vc1.
//  4 credit[0]=2, consume and return on vc0 same cycle -> credit[0] stays 2, err_o=0.
//  5 return credit on vc0 at CREDIT_DEPTH -> credit[0]=4, err_o=1 until rst.
//  6 rst asserted mid BODY of cnt=5 pkt -> next cycle flit_valid_o=0, busy_o=0, all credits=4.

Source files
------------

// File: rtl/noc_packetizer_if.sv
// Descriptor, body, flit and credit signals of the NoC source packetizer.
// Stats ports exist only when NOC_PKT_STATS_EN is defined.
interface noc_packetizer_if #(
    parameter int MESH_SIZE_X       = 5,
    parameter int MESH_SIZE_Y       = 5,
    parameter int VC_NUM            = 2,
    parameter int HEAD_PAYLOAD_SIZE = 16,
    parameter int MAX_BODY_FLITS    = 7
);
    localparam int DX = $clog2(MESH_SIZE_X);
    localparam int DY = $clog2(MESH_SIZE_Y);
    localparam int VS = $clog2(VC_NUM);
    localparam int FD = DX + DY + HEAD_PAYLOAD_SIZE;
    localparam int BC = $clog2(MAX_BODY_FLITS + 1);

    logic                         pkt_valid_i;
    logic                         pkt_ready_o;
    logic [DX-1:0]                pkt_x_dest_i;
    logic [DY-1:0]                pkt_y_dest_i;
    logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i;
    logic [BC-1:0]                pkt_body_cnt_i;
    logic                         body_valid_i;
    logic                         body_ready_o;
    logic [FD-1:0]                body_data_i;
    logic                         flit_valid_o;
    logic [2+VS+FD-1:0]           flit_o;
    logic                         credit_valid_i;
    logic [VS-1:0]                credit_vc_i;
    logic                         busy_o;
    logic                         err_o;
`ifdef NOC_PKT_STATS_EN
    logic [15:0]                  pkt_cnt_o;
    logic [15:0]                  flit_cnt_o;
`endif

    modport slave (
        input  pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i,
        input  pkt_head_pl_i, pkt_body_cnt_i,
        input  body_valid_i, body_data_i,
        input  credit_valid_i, credit_vc_i,
        output pkt_ready_o, body_ready_o,
        output flit_valid_o, flit_o, busy_o, err_o
`ifdef NOC_PKT_STATS_EN
        , output pkt_cnt_o, flit_cnt_o
`endif
    );

    modport master (
        output pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i,
        output pkt_head_pl_i, pkt_body_cnt_i,
        output body_valid_i, body_data_i,
        output credit_valid_i, credit_vc_i,
        input  pkt_ready_o, body_ready_o,
        input  flit_valid_o, flit_o, busy_o, err_o
`ifdef NOC_PKT_STATS_EN
        , input pkt_cnt_o, flit_cnt_o
`endif
    );
endinterface

// File: rtl/noc_packetizer.sv
// NoC source packetizer: descriptor + body stream -> credit-gated flits.
// Optional NOC_PKT_STATS_EN adds packet/flit counters.
module noc_packetizer #(
    parameter int MESH_SIZE_X       = 5,
    parameter int MESH_SIZE_Y       = 5,
    parameter int VC_NUM            = 2,
    parameter int HEAD_PAYLOAD_SIZE = 16,
    parameter int MAX_BODY_FLITS    = 7,
    parameter int CREDIT_DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    noc_packetizer_if.slave         bus
);
    localparam int DX = $clog2(MESH_SIZE_X);
    localparam int DY = $clog2(MESH_SIZE_Y);
    localparam int VS = $clog2(VC_NUM);
    localparam int FD = DX + DY + HEAD_PAYLOAD_SIZE;
    localparam int BC = $clog2(MAX_BODY_FLITS + 1);
    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam int FW = 2 + VS + FD;

    localparam logic [1:0] L_HEAD     = 2'd0;
    localparam logic [1:0] L_BODY     = 2'd1;
    localparam logic [1:0] L_TAIL     = 2'd2;
    localparam logic [1:0] L_HEADTAIL = 2'd3;

    typedef enum logic {IDLE, BODY} state_t;

    state_t         state_q;
    logic [CW-1:0]  credit_q [VC_NUM];
    logic [CW-1:0]  credit_d [VC_NUM];
    logic [VS-1:0]  rr_ptr_q;
    logic [VS-1:0]  vc_q;
    logic [BC-1:0]  rem_q;
    logic           flit_valid_q;
    logic [FW-1:0]  flit_q;
    logic           err_q;
    logic           err_d;

    logic [VS-1:0]  sel_vc;
    logic [VS-1:0]  rr_next;
    logic [VS-1:0]  cons_vc;
    logic           any_credit;
    logic           pkt_ready;
    logic           body_ready;
    logic           pkt_fire;
    logic           body_fire;
    logic [BC-1:0]  cnt_c;

    // Round-robin search from rr_ptr over registered counts only
    always_comb begin
        logic found;
        int   idx;
        sel_vc     = '0;
        found      = 1'b0;
        any_credit = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = (int'(rr_ptr_q) + i) % VC_NUM;
            if (!found && credit_q[idx] != '0) begin
                sel_vc = VS'(idx);
                found  = 1'b1;
            end
            if (credit_q[i] != '0) any_credit = 1'b1;
        end
    end

    assign rr_next    = (sel_vc == VS'(VC_NUM - 1)) ? '0 : sel_vc + 1'b1;
    assign pkt_ready  = !rst && state_q == IDLE && any_credit;
    assign body_ready = !rst && state_q == BODY && credit_q[vc_q] != '0;
    assign pkt_fire   = bus.pkt_valid_i && pkt_ready;
    assign body_fire  = bus.body_valid_i && body_ready;
    assign cons_vc    = pkt_fire ? sel_vc : vc_q;
    assign cnt_c      = (bus.pkt_body_cnt_i > BC'(MAX_BODY_FLITS))
                      ? BC'(MAX_BODY_FLITS) : bus.pkt_body_cnt_i;

    always_comb begin
        logic inc;
        logic dec;
        err_d = err_q;
        if (bus.credit_valid_i && int'(bus.credit_vc_i) >= VC_NUM)
            err_d = 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
            credit_d[v] = credit_q[v];
            inc = bus.credit_valid_i && int'(bus.credit_vc_i) == v;
            dec = (pkt_fire || body_fire) && int'(cons_vc) == v;
            if (inc && !dec) begin
                if (credit_q[v] == CW'(CREDIT_DEPTH)) err_d = 1'b1;
                else credit_d[v] = credit_q[v] + 1'b1;
            end else if (dec && !inc) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            vc_q         <= '0;
            rem_q        <= '0;
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
            err_q        <= 1'b0;
            for (int v = 0; v < VC_NUM; v++)
                credit_q[v] <= CW'(CREDIT_DEPTH);
        end else begin
            credit_q     <= credit_d;
            err_q        <= err_d;
            flit_valid_q <= pkt_fire || body_fire;
            unique case (state_q)
                IDLE: if (pkt_fire) begin
                    rr_ptr_q <= rr_next;
                    flit_q   <= {(cnt_c == '0) ? L_HEADTAIL : L_HEAD, sel_vc,
                                 bus.pkt_x_dest_i, bus.pkt_y_dest_i,
                                 bus.pkt_head_pl_i};
                    if (cnt_c != '0) begin
                        vc_q    <= sel_vc;
                        rem_q   <= cnt_c;
                        state_q <= BODY;
                    end
                end
                BODY: if (body_fire) begin
                    flit_q <= {(rem_q == BC'(1)) ? L_TAIL : L_BODY, vc_q,
                               bus.body_data_i};
                    rem_q  <= rem_q - 1'b1;
                    if (rem_q == BC'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef NOC_PKT_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] flit_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else begin
            if (pkt_fire) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (pkt_fire || body_fire) flit_cnt_q <= flit_cnt_q + 16'd1;
        end
    end

    assign bus.pkt_cnt_o  = pkt_cnt_q;
    assign bus.flit_cnt_o = flit_cnt_q;
`endif

    assign bus.pkt_ready_o  = pkt_ready;
    assign bus.body_ready_o = body_ready;
    assign bus.flit_valid_o = flit_valid_q;
    assign bus.flit_o       = flit_q;
    assign bus.busy_o       = state_q == BODY;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer with default parameters.
// Flit = {label[1:0], vc[0], x[2:0], y[2:0], pl[15:0]} = 25 bits.
module tb_noc_packetizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    noc_packetizer_if bus ();

    noc_packetizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] fl(logic [1:0] l, logic v,
                                       logic [21:0] d);
        return {l, v, d};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.pkt_valid_i    = 1'b0;
        bus.pkt_x_dest_i   = '0;
        bus.pkt_y_dest_i   = '0;
        bus.pkt_head_pl_i  = '0;
        bus.pkt_body_cnt_i = '0;
        bus.body_valid_i   = 1'b0;
        bus.body_data_i    = '0;
        bus.credit_valid_i = 1'b0;
        bus.credit_vc_i    = '0;
        step();
        step();
        chk("rst_pkt_ready", 32'(bus.pkt_ready_o), 0);
        chk("rst_body_ready", 32'(bus.body_ready_o), 0);
        chk("rst_flit_valid", 32'(bus.flit_valid_o), 0);
        chk("rst_flit", 32'(bus.flit_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_cr0", 32'(dut.credit_q[0]), 4);
        chk("rst_cr1", 32'(dut.credit_q[1]), 4);
        rst = 1'b0;
        #1;
        chk("idle_pkt_ready", 32'(bus.pkt_ready_o), 1);

        // HEADTAIL packet
        bus.pkt_x_dest_i   = 3'd3;
        bus.pkt_y_dest_i   = 3'd2;
        bus.pkt_head_pl_i  = 16'hBEEF;
        bus.pkt_body_cnt_i = 3'd0;
        bus.pkt_valid_i    = 1'b1;
        step();
        bus.pkt_valid_i = 1'b0;
        chk("t1_valid", 32'(bus.flit_valid_o), 1);
        chk("t1_flit", 32'(bus.flit_o),
            32'(fl(2'd3, 1'b0, {3'd3, 3'd2, 16'hBEEF})));
        chk("t1_cr0", 32'(dut.credit_q[0]), 3);
        chk("t1_busy", 32'(bus.busy_o), 0);

        // HEAD/BODY/TAIL packet on vc1
        bus.pkt_x_dest_i   = 3'd1;
        bus.pkt_y_dest_i   = 3'd4;
        bus.pkt_head_pl_i  = 16'h1234;
        bus.pkt_body_cnt_i = 3'd2;
        bus.pkt_valid_i    = 1'b1;
        step();
        bus.pkt_valid_i = 1'b0;
        chk("t2_head", 32'(bus.flit_o),
            32'(fl(2'd0, 1'b1, {3'd1, 3'd4, 16'h1234})));
        chk("t2_busy", 32'(bus.busy_o), 1);
        chk("t2_pkt_ready", 32'(bus.pkt_ready_o), 0);
        chk("t2_body_ready", 32'(bus.body_ready_o), 1);
        bus.body_valid_i = 1'b1;
        bus.body_data_i  = 22'hA;
        step();
        chk("t2_body", 32'(bus.flit_o), 32'(fl(2'd1, 1'b1, 22'hA)));
        bus.body_data_i = 22'hB;
        step();
        bus.body_valid_i = 1'b0;
        chk("t2_tail", 32'(bus.flit_o), 32'(fl(2'd2, 1'b1, 22'hB)));
        chk("t2_tail_valid", 32'(bus.flit_valid_o), 1);
        chk("t2_idle", 32'(bus.busy_o), 0);
        chk("t2_cr1", 32'(dut.credit_q[1]), 1);
        step();
        chk("t2_bubble", 32'(bus.flit_valid_o), 0);
        bus.pkt_body_cnt_i = 3'd0;
        bus.pkt_valid_i    = 1'b1;
        step();
        bus.pkt_valid_i = 1'b0;
        chk("t2_next_vc0", 32'(bus.flit_o),
            32'(fl(2'd3, 1'b0, {3'd1, 3'd4, 16'h1234})));

        // Exhaust all credits with 8 HEADTAIL packets
        do_reset();
        bus.pkt_x_dest_i   = 3'd2;
        bus.pkt_y_dest_i   = 3'd1;
        bus.pkt_head_pl_i  = 16'h00C3;
        bus.pkt_body_cnt_i = 3'd0;
        bus.pkt_valid_i    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_vc_alt", 32'(bus.flit_o),
                32'(fl(2'd3, 1'(i % 2), {3'd2, 3'd1, 16'h00C3})));
        end
        chk("t3_no_credit", 32'(bus.pkt_ready_o), 0);
        bus.credit_valid_i = 1'b1;
        bus.credit_vc_i    = 1'b1;
        step();
        bus.credit_valid_i = 1'b0;
        chk("t3_stalled", 32'(bus.flit_valid_o), 0);
        chk("t3_ready_back", 32'(bus.pkt_ready_o), 1);
        step();
        bus.pkt_valid_i = 1'b0;
        chk("t3_vc1_valid", 32'(bus.flit_valid_o), 1);
        chk("t3_vc1", 32'(bus.flit_o),
            32'(fl(2'd3, 1'b1, {3'd2, 3'd1, 16'h00C3})));

        // Same-cycle consume and return on vc0
        do_reset();
        bus.pkt_body_cnt_i = 3'd2;
        bus.pkt_valid_i    = 1'b1;
        step();
        bus.pkt_valid_i  = 1'b0;
        bus.body_valid_i = 1'b1;
        bus.body_data_i  = 22'h1;
        step();
        chk("t4_cr0_pre", 32'(dut.credit_q[0]), 2);
        bus.body_data_i    = 22'h2;
        bus.credit_valid_i = 1'b1;
        bus.credit_vc_i    = 1'b0;
        step();
        bus.body_valid_i   = 1'b0;
        bus.credit_valid_i = 1'b0;
        chk("t4_tail", 32'(bus.flit_o), 32'(fl(2'd2, 1'b0, 22'h2)));
        chk("t4_cr0_same", 32'(dut.credit_q[0]), 2);
        chk("t4_err", 32'(bus.err_o), 0);

        // Credit overflow is sticky until reset
        do_reset();
        bus.credit_valid_i = 1'b1;
        bus.credit_vc_i    = 1'b0;
        step();
        bus.credit_valid_i = 1'b0;
        chk("t5_cr0_sat", 32'(dut.credit_q[0]), 4);
        chk("t5_err", 32'(bus.err_o), 1);
        step();
        step();
        chk("t5_err_sticky", 32'(bus.err_o), 1);
        do_reset();
        chk("t5_err_clr", 32'(bus.err_o), 0);

        // Reset in the middle of a 5-body packet
        bus.pkt_body_cnt_i = 3'd5;
        bus.pkt_valid_i    = 1'b1;
        step();
        bus.pkt_valid_i  = 1'b0;
        bus.body_valid_i = 1'b1;
        bus.body_data_i  = 22'h33;
        step();
        step();
        chk("t6_busy_pre", 32'(bus.busy_o), 1);
        rst = 1'b1;
        #1;
        chk("t6_body_ready_rst", 32'(bus.body_ready_o), 0);
        step();
        chk("t6_valid", 32'(bus.flit_valid_o), 0);
        chk("t6_busy", 32'(bus.busy_o), 0);
        chk("t6_cr0", 32'(dut.credit_q[0]), 4);
        chk("t6_cr1", 32'(dut.credit_q[1]), 4);
        rst = 1'b0;
        step();
        bus.body_valid_i = 1'b0;
        chk("t6_no_tail", 32'(bus.flit_valid_o), 0);
        chk("t6_pkt_ready", 32'(bus.pkt_ready_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
